// File: rtl/snn_image_loader.sv
// SNN image loader: unpacks UART bytes LSB-first into the input-unit RAM,
// starts the inference core and sends the classified digit back as ASCII.
module snn_image_loader #(
  parameter int         NUM_PIXELS = 784,
  parameter logic [7:0] ASCII_BASE = 8'h30,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic       ram_d,
  output logic       snn_start,
  input  logic       snn_done,
  input  logic [3:0] snn_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       rx_drop
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_UNPACK,
    S_START,
    S_WAIT,
    S_TX,
    S_TXW
  } state_t;

  localparam logic [9:0] LAST_PIX = 10'(NUM_PIXELS - 1);

  state_t     state_q;
  logic [9:0] pixel_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] tx_data_q;
  logic [7:0] tx_char_d;
  logic       snn_start_q;
  logic       tx_start_q;
  logic       busy_q;
  logic       rx_drop_q;

  // ASCII result byte; out-of-range digits map to the bad-char marker
  always_comb begin
    tx_char_d = ASCII_BASE + {4'b0000, snn_digit};
    if (snn_digit > 4'd9) begin
      tx_char_d = BAD_CHAR;
    end
  end

  // Control FSM with registered strobes, counters and result byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      pixel_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_data_q   <= '0;
      snn_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      snn_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      rx_drop_q   <= rx_rdy && (state_q != S_LOAD);
      unique case (state_q)
        S_LOAD: begin
          if (rx_rdy) begin
            shift_q   <= rx_data;
            bit_cnt_q <= '0;
            state_q   <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7 && pixel_cnt_q == LAST_PIX) begin
            // last pixel: counter holds, START clears it
            state_q     <= S_START;
            snn_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            pixel_cnt_q <= pixel_cnt_q + 10'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_LOAD;
            end
          end
        end
        S_START: begin
          pixel_cnt_q <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (snn_done) begin
            tx_data_q  <= tx_char_d;
            tx_start_q <= 1'b1;
            state_q    <= S_TX;
          end
        end
        S_TX: begin
          state_q <= S_TXW;
        end
        S_TXW: begin
          if (tx_done) begin
            busy_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign ram_we    = (state_q == S_UNPACK);
  assign ram_addr  = pixel_cnt_q;
  assign ram_d     = shift_q[0];
  assign snn_start = snn_start_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// Scoreboard bench for snn_image_loader: RAM writes, start pulses,
// result bytes and dropped bytes are predicted at drive time.
module tb_snn_image_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       snn_done = 1'b0;
  logic [3:0] snn_digit = '0;
  logic       tx_done = 1'b0;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       snn_start;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       rx_drop;

  snn_image_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .snn_start (snn_start),
    .snn_done  (snn_done),
    .snn_digit (snn_digit),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .rx_drop   (rx_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
  endtask

  typedef struct packed {
    logic [9:0] a;
    logic       d;
  } wr_t;

  wr_t wr_q[$];
  int  tx_q[$];
  wr_t e_w;

  int exp_addr = 0;
  int writes_exp = 0;
  int writes_seen = 0;
  int starts_exp = 0;
  int starts_seen = 0;
  int tx_exp = 0;
  int tx_seen = 0;
  int drops_exp = 0;
  int drops_seen = 0;
  int last_rx_cyc = 0;
  int done_cyc = 0;

  // output monitor: pops the scoreboard as the DUT produces results
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        writes_seen++;
        if (wr_q.size() == 0) check("wr_extra", ram_addr, -1);
        else begin
          e_w = wr_q.pop_front();
          check("wr_addr", ram_addr, e_w.a);
          check("wr_data", ram_d, e_w.d);
        end
      end
      if (snn_start) begin
        starts_seen++;
        check("start_lat", cyc - last_rx_cyc, 9);
      end
      if (tx_start) begin
        tx_seen++;
        if (tx_q.size() == 0) check("tx_extra", tx_data, -1);
        else check("tx_data", tx_data, tx_q.pop_front());
        check("tx_lat", cyc - done_cyc, 1);
      end
      if (rx_drop) drops_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit drop3);
    @(posedge clk);
    #1;
    rx_rdy = 1'b1;
    rx_data = b;
    last_rx_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      wr_q.push_back(wr_t'({10'(exp_addr), b[i]}));
      exp_addr++;
      writes_exp++;
    end
    if (exp_addr == 784) begin
      exp_addr = 0;
      starts_exp++;
    end
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    if (drop3) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      rx_rdy = 1'b1;
      rx_data = ~b;
      drops_exp++;
      @(posedge clk);
      #1;
      rx_rdy = 1'b0;
      repeat (5) @(posedge clk);
    end else begin
      repeat (8) @(posedge clk);
    end
  endtask

  task automatic finish_image(input logic [3:0] digit,
                              input logic [7:0] exp_char,
                              input bit drop_wait);
    int n;
    n = 0;
    while (starts_seen < starts_exp && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("start_seen", starts_seen, starts_exp);
    @(posedge clk);
    #1;
    check("busy_wait", busy, 1);
    if (drop_wait) begin
      rx_rdy = 1'b1;
      rx_data = 8'h55;
      drops_exp++;
      @(posedge clk);
      #1;
      rx_rdy = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    snn_digit = digit;
    snn_done = 1'b1;
    done_cyc = cyc;
    tx_q.push_back(exp_char);
    tx_exp++;
    @(posedge clk);
    #1;
    snn_done = 1'b0;
    snn_digit = '0;
    n = 0;
    while (tx_seen < tx_exp && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("tx_seen", tx_seen, tx_exp);
    repeat (4) @(posedge clk);
    #1;
    check("tx_hold", tx_data, exp_char);
    check("busy_txw", busy, 1);
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    check("busy_end", busy, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_start"}, snn_start, 0);
    check({tag, "_txs"}, tx_start, 0);
    check({tag, "_txd"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop"}, rx_drop, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    rst = 1'b0;

    // stray done pulses while loading must be ignored
    @(posedge clk);
    #1;
    snn_done = 1'b1;
    snn_digit = 4'd1;
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    snn_done = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_busy", busy, 0);

    for (int i = 0; i < 98; i++) send_byte(8'hA5, 1'b0);
    finish_image(4'd7, 8'h37, 1'b0);

    for (int i = 0; i < 98; i++) send_byte(8'($urandom), 1'b0);
    finish_image(4'hC, 8'h3F, 1'b0);

    for (int i = 0; i < 98; i++) send_byte(8'($urandom), i == 10);
    finish_image(4'd5, 8'h35, 1'b1);

    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_q_empty", wr_q.size(), 0);
    wr_q.delete();
    exp_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 98; i++) send_byte(8'($urandom), 1'b0);
    finish_image(4'd2, 8'h32, 1'b0);

    for (int i = 0; i < 98; i++) send_byte(8'($urandom), 1'b0);
    finish_image(4'd3, 8'h33, 1'b0);
    for (int i = 0; i < 98; i++) send_byte(8'($urandom), 1'b0);
    finish_image(4'd9, 8'h39, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("writes", writes_seen, writes_exp);
    check("starts", starts_seen, starts_exp);
    check("tx_count", tx_seen, tx_exp);
    check("drops", drops_seen, drops_exp);
    check("wr_q_left", wr_q.size(), 0);
    check("tx_q_left", tx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
